// File: rtl/h264_inverse_transform.sv
// rtl/h264_inverse_transform.sv - 4x4 H.264 inverse integer core transform with zigzag load buffer
// A load buffer fills while the work matrix is row-transformed, then column-transformed row by row on output.
module h264_inverse_transform #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 10
) (
  input  logic                   CLK,
  input  logic                   RESET,
  output logic                   READY,
  input  logic                   ENABLE,
  input  logic signed [IN_W-1:0] WIN,
  output logic                   VALID,
  input  logic                   OREADY,
  output logic [4*OUT_W-1:0]     XOUT,
  output logic [1:0]             ROW
);
  localparam int RW = IN_W + 2;
  localparam int CW = IN_W + 4;
  localparam logic signed [CW-1:0] SAT_HI = CW'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [CW-1:0] SAT_LO = CW'(-(1 << (OUT_W - 1)));

  typedef enum logic [1:0] {IDLE, ROWS, OUT} state_t;
  state_t state, state_nx;

  logic signed [IN_W-1:0] lbuf [16];
  logic signed [RW-1:0]   wm   [16];
  logic [3:0]             cnt;
  logic                   load_full;
  logic [1:0]             rc;
  logic                   accept, xfer;
  logic [1:0]             out_sel;

  logic signed [RW-1:0]   rw0, rw1, rw2, rw3, re, rf, rg, rh;
  logic signed [CW-1:0]   cw0, cw1, cw2, cw3, ce, cf, cg, ch, cy, cr;
  logic [4*OUT_W-1:0]     col_row;

  // Zigzag scan index to raster position (row*4 + col).
  function automatic logic [3:0] zz_pos(input logic [3:0] idx);
    case (idx)
      4'd0:    zz_pos = 4'd0;
      4'd1:    zz_pos = 4'd1;
      4'd2:    zz_pos = 4'd4;
      4'd3:    zz_pos = 4'd8;
      4'd4:    zz_pos = 4'd5;
      4'd5:    zz_pos = 4'd2;
      4'd6:    zz_pos = 4'd3;
      4'd7:    zz_pos = 4'd6;
      4'd8:    zz_pos = 4'd9;
      4'd9:    zz_pos = 4'd12;
      4'd10:   zz_pos = 4'd13;
      4'd11:   zz_pos = 4'd10;
      4'd12:   zz_pos = 4'd7;
      4'd13:   zz_pos = 4'd11;
      4'd14:   zz_pos = 4'd14;
      default: zz_pos = 4'd15;
    endcase
  endfunction

  assign READY   = ~load_full | (state == IDLE);
  assign accept  = ENABLE & READY;
  assign xfer    = load_full & (state == IDLE);
  // While a row is held, the next row to register is rc+1.
  assign out_sel = VALID ? rc + 2'd1 : rc;

  always_comb begin
    rw0 = wm[{rc, 2'd0}];
    rw1 = wm[{rc, 2'd1}];
    rw2 = wm[{rc, 2'd2}];
    rw3 = wm[{rc, 2'd3}];
    re  = rw0 + rw2;
    rf  = rw0 - rw2;
    rg  = (rw1 >>> 1) - rw3;
    rh  = rw1 + (rw3 >>> 1);
  end

  always_comb begin
    col_row = '0;
    cw0 = '0; cw1 = '0; cw2 = '0; cw3 = '0;
    ce  = '0; cf  = '0; cg  = '0; ch  = '0;
    cy  = '0; cr  = '0;
    for (int c = 0; c < 4; c++) begin
      cw0 = {{(CW-RW){wm[4'(c)][RW-1]}},      wm[4'(c)]};
      cw1 = {{(CW-RW){wm[4'(4 + c)][RW-1]}},  wm[4'(4 + c)]};
      cw2 = {{(CW-RW){wm[4'(8 + c)][RW-1]}},  wm[4'(8 + c)]};
      cw3 = {{(CW-RW){wm[4'(12 + c)][RW-1]}}, wm[4'(12 + c)]};
      ce  = cw0 + cw2;
      cf  = cw0 - cw2;
      cg  = (cw1 >>> 1) - cw3;
      ch  = cw1 + (cw3 >>> 1);
      case (out_sel)
        2'd0:    cy = ce + ch;
        2'd1:    cy = cf + cg;
        2'd2:    cy = cf - cg;
        default: cy = ce - ch;
      endcase
      cr = (cy + CW'(32)) >>> 6;
      if (cr > SAT_HI)      col_row[c*OUT_W +: OUT_W] = SAT_HI[OUT_W-1:0];
      else if (cr < SAT_LO) col_row[c*OUT_W +: OUT_W] = SAT_LO[OUT_W-1:0];
      else                  col_row[c*OUT_W +: OUT_W] = cr[OUT_W-1:0];
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (xfer) state_nx = ROWS;
      ROWS:    if (rc == 2'd3) state_nx = OUT;
      OUT:     if (VALID && OREADY && rc == 2'd3) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      load_full <= 1'b0;
      rc        <= 2'd0;
      VALID     <= 1'b0;
      XOUT      <= '0;
      ROW       <= 2'd0;
    end else begin
      state <= state_nx;
      if (accept) cnt <= cnt + 4'd1;
      if (xfer) load_full <= 1'b0;
      else if (accept && cnt == 4'd15) load_full <= 1'b1;
      case (state)
        ROWS: rc <= rc + 2'd1;
        OUT: begin
          if (!VALID) begin
            XOUT  <= col_row;
            ROW   <= rc;
            VALID <= 1'b1;
          end else if (OREADY) begin
            if (rc == 2'd3) begin
              VALID <= 1'b0;
              rc    <= 2'd0;
            end else begin
              XOUT <= col_row;
              ROW  <= rc + 2'd1;
              rc   <= rc + 2'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Matrix storage carries no reset; control state alone decides what is live.
  always_ff @(posedge CLK) begin
    if (accept) lbuf[zz_pos(cnt)] <= WIN;
    if (xfer) begin
      for (int k = 0; k < 16; k++) wm[k] <= {{2{lbuf[k][IN_W-1]}}, lbuf[k]};
    end else if (state == ROWS) begin
      wm[{rc, 2'd0}] <= re + rh;
      wm[{rc, 2'd1}] <= rf + rg;
      wm[{rc, 2'd2}] <= rf - rg;
      wm[{rc, 2'd3}] <= re - rh;
    end
  end

endmodule

// File: tb/tb_h264_inverse_transform.sv
// tb/tb_h264_inverse_transform.sv - bench for h264_inverse_transform: vector table, hand sequences, random blocks vs model
module tb_h264_inverse_transform;
  localparam int IN_W  = 16;
  localparam int OUT_W = 10;
  localparam int PW    = 4*OUT_W + 2;
  localparam int ZR[16] = '{0,0,1,2,1,0,0,1,2,3,3,2,1,2,3,3};
  localparam int ZC[16] = '{0,1,0,0,1,2,3,2,1,0,1,2,3,3,2,3};

  logic                   CLK = 1'b0;
  logic                   RESET = 1'b0;
  logic                   READY;
  logic                   ENABLE = 1'b0;
  logic signed [IN_W-1:0] WIN = '0;
  logic                   VALID;
  logic                   OREADY = 1'b1;
  logic [4*OUT_W-1:0]     XOUT;
  logic [1:0]             ROW;

  int checks = 0;
  int errors = 0;
  bit rand_ord = 1'b0;
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] got_q[$];

  typedef struct { int zz; int val; int r0; int r1; int r2; int r3; int c0; int c1; int c2; int c3; } vec_t;
  vec_t vt[6];

  h264_inverse_transform #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .CLK(CLK), .RESET(RESET), .READY(READY), .ENABLE(ENABLE), .WIN(WIN),
    .VALID(VALID), .OREADY(OREADY), .XOUT(XOUT), .ROW(ROW)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (RESET && VALID && OREADY) got_q.push_back({ROW, XOUT});

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
    if (rand_ord) OREADY = 1'($urandom_range(0, 1));
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] pack_row(input int r, input int v[4]);
    logic [PW-1:0] p;
    p = '0;
    p[PW-1 -: 2] = 2'(r);
    for (int c = 0; c < 4; c++) p[c*OUT_W +: OUT_W] = OUT_W'(v[c]);
    return p;
  endfunction

  function automatic int bfly(input int a, input int b, input int c, input int d, input int sel);
    int e, f, g, h;
    e = a + c;
    f = a - c;
    g = (b >>> 1) - d;
    h = b + (d >>> 1);
    case (sel)
      0:       return e + h;
      1:       return f + g;
      2:       return f - g;
      default: return e - h;
    endcase
  endfunction

  task automatic model_push(input int c[16]);
    int m[4][4];
    int t[4][4];
    int v[4];
    int y;
    for (int k = 0; k < 16; k++) m[ZR[k]][ZC[k]] = c[k];
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) t[i][j] = bfly(m[i][0], m[i][1], m[i][2], m[i][3], j);
    for (int r = 0; r < 4; r++) begin
      for (int col = 0; col < 4; col++) begin
        y = (bfly(t[0][col], t[1][col], t[2][col], t[3][col], r) + 32) >>> 6;
        if (y > 511) y = 511;
        if (y < -512) y = -512;
        v[col] = y;
      end
      exp_q.push_back(pack_row(r, v));
    end
  endtask

  task automatic push_vec(input vec_t x);
    int rv[4];
    int cv[4];
    int v[4];
    rv[0] = x.r0; rv[1] = x.r1; rv[2] = x.r2; rv[3] = x.r3;
    cv[0] = x.c0; cv[1] = x.c1; cv[2] = x.c2; cv[3] = x.c3;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) v[c] = rv[r] * cv[c];
      exp_q.push_back(pack_row(r, v));
    end
  endtask

  function automatic int rcoef();
    case ($urandom_range(0, 3))
      0:       return 0;
      1:       return int'($urandom_range(0, 600)) - 300;
      2:       return int'($urandom_range(0, 65535)) - 32768;
      default: return int'($urandom_range(0, 4000)) - 2000;
    endcase
  endfunction

  task automatic send_block(input int c[16], input bit gaps);
    int  k;
    int  guard;
    logic take;
    k = 0;
    guard = 0;
    while (k < 16) begin
      ENABLE = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      WIN    = IN_W'(c[k]);
      take   = ENABLE && READY;
      tick();
      if (take) k++;
      guard++;
      if (guard > 2000) begin
        checks++;
        errors++;
        $display("FAIL send_block: READY stuck low, %0d of 16 coefficients taken", k);
        break;
      end
    end
    ENABLE = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (got_q.size() < exp_q.size() && g < 600) begin
      tick();
      g++;
    end
    repeat (3) tick();
  endtask

  task automatic check_rows(input string name);
    logic [PW-1:0] e;
    logic [PW-1:0] a;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin
        errors++;
        $display("FAIL %s: row missing, required row %0d xout %h", name, e[PW-1 -: 2], e[4*OUT_W-1:0]);
      end else begin
        a = got_q.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL %s: got row %0d xout %h, required row %0d xout %h",
                   name, a[PW-1 -: 2], a[4*OUT_W-1:0], e[PW-1 -: 2], e[4*OUT_W-1:0]);
        end
      end
    end
    checks++;
    if (got_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d extra rows, required 0", name, got_q.size());
      got_q.delete();
    end
  endtask

  initial begin
    int c[16];
    int lat;
    int g;

    vt[0] = '{0,     64,   1,   1,   1,   1,  1, 1, 1,  1};
    vt[1] = '{0,    -64,  -1,  -1,  -1,  -1,  1, 1, 1,  1};
    vt[2] = '{1,     64,   1,   1,   1,   1,  1, 1, 0, -1};
    vt[3] = '{0,  32767, 511, 511, 511, 511,  1, 1, 1,  1};
    vt[4] = '{0, -32768,-512,-512,-512,-512,  1, 1, 1,  1};
    vt[5] = '{2,     64,   1,   1,   0,  -1,  1, 1, 1,  1};

    repeat (3) tick();
    chk("reset_valid", VALID, 0);
    chk("reset_xout", XOUT, 0);
    chk("reset_row", ROW, 0);
    chk("reset_ready", READY, 1);
    RESET = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 16; k++) c[k] = 0;
      c[vt[i].zz] = vt[i].val;
      push_vec(vt[i]);
      send_block(c, 1'b0);
      lat = 0;
      while (!VALID && lat < 20) begin
        tick();
        lat++;
      end
      chk($sformatf("first_valid_latency_%0d", i), lat, 6);
      drain();
      check_rows($sformatf("table_%0d", i));
    end

    // Two blocks under backpressure; the second fills the load buffer while the first is stalled.
    OREADY = 1'b0;
    for (int k = 0; k < 16; k++) c[k] = rcoef();
    model_push(c);
    send_block(c, 1'b0);
    for (int k = 0; k < 16; k++) c[k] = rcoef();
    model_push(c);
    send_block(c, 1'b0);
    chk("bp_ready_low", READY, 0);
    ENABLE = 1'b1;
    for (int n = 0; n < 20; n++) begin
      WIN = IN_W'($urandom);
      tick();
      chk("bp_hold_row0", {VALID, ROW, XOUT}, {1'b1, exp_q[0]});
      chk("bp_ready_held", READY, 0);
    end
    ENABLE = 1'b0;
    OREADY = 1'b1;
    drain();
    check_rows("backpressure");
    for (int k = 0; k < 16; k++) c[k] = rcoef();
    model_push(c);
    send_block(c, 1'b1);
    drain();
    check_rows("after_ignored_enable");

    // Reset during a partial load.
    for (int k = 0; k < 7; k++) begin
      ENABLE = 1'b1;
      WIN = IN_W'(rcoef() + 1);
      tick();
    end
    ENABLE = 1'b0;
    RESET = 1'b0;
    tick();
    RESET = 1'b1;
    tick();
    for (int k = 0; k < 16; k++) c[k] = 0;
    c[0] = 64;
    push_vec(vt[0]);
    send_block(c, 1'b0);
    drain();
    check_rows("reset_mid_load");

    // Reset while a row is being presented.
    OREADY = 1'b0;
    for (int k = 0; k < 16; k++) c[k] = rcoef();
    send_block(c, 1'b0);
    lat = 0;
    while (!VALID && lat < 20) begin
      tick();
      lat++;
    end
    chk("rst_out_valid_before", VALID, 1);
    RESET = 1'b0;
    tick();
    chk("rst_out_valid", VALID, 0);
    chk("rst_out_row", ROW, 0);
    RESET = 1'b1;
    g = 0;
    for (int n = 0; n < 12; n++) begin
      tick();
      if (VALID) g++;
    end
    chk("rst_out_no_valid_after", g, 0);
    OREADY = 1'b1;
    repeat (2) tick();
    check_rows("rst_out");

    // Random blocks, random input gaps and random output stalls.
    rand_ord = 1'b1;
    for (int b = 0; b < 12; b++) begin
      for (int k = 0; k < 16; k++) c[k] = rcoef();
      model_push(c);
      send_block(c, 1'b1);
    end
    drain();
    rand_ord = 1'b0;
    OREADY = 1'b1;
    check_rows("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/h264_inverse_transform.md
Name: h264_inverse_transform

Overview:
- 4x4 H.264 inverse integer core transform for the reconstruction loop.
- Performs the inverse of the forward core transform. It consumes dequantised coefficients one per cycle in zigzag order and emits residual rows of four pixels per cycle.
- A load buffer accepts the next block while the work matrix row-transforms and outputs the current block.
- Output handshake is VALID/OREADY so the reconstruction adder can apply backpressure.

Parameters:
IN_W, 16, signed coefficient width
OUT_W, 10, signed residual width after rounding and saturation

Ports:
CLK  in  1  clock
RESET  in  1  reset, synchronous, active-low
READY  out  1  coefficient may be accepted this cycle (combinational)
ENABLE  in  1  WIN valid; coefficient taken on rising edge when ENABLE & READY
WIN  in  IN_W  signed coefficient, zigzag order, index 0 first
VALID  out  1  XOUT/ROW hold a residual row
OREADY  in  1  downstream accepts row when VALID & OREADY
XOUT  out  4*OUT_W  residual row, column 0 in LSBs, signed
ROW  out  2  row index (0..3) of XOUT

Behaviour:
Reset (RESET=0 at an edge):
- Load count = 0, load_full = 0, state = IDLE, row counter = 0.
- VALID = 0, XOUT = 0, ROW = 0.
- Matrix contents are don't-care.
- Reset mid-block discards any partial load and any in-flight block; no VALID until a full new block has loaded.

Load:
- Each accepted coefficient is written to the 4x4 load buffer at the zigzag position given by the load count.
- Zigzag index -> (row,col):
  0(0,0) 1(0,1) 2(1,0) 3(2,0) 4(1,1) 5(0,2) 6(0,3) 7(1,2) 8(2,1) 9(3,0) 10(3,1) 11(2,2) 12(1,3) 13(2,3) 14(3,2) 15(3,3)
- Count wraps 15->0 on the 16th coefficient; load_full is set on that edge.
- READY = ~load_full | (state==IDLE).
- ENABLE while READY=0 is ignored: no write, count unchanged.

Transfer:
- At an edge where load_full & state==IDLE: work matrix <= load buffer, load_full cleared, state -> ROW.
- A coefficient may be written to the load buffer on the same edge. The transfer takes the old contents.

ROW state (4 cycles, one row r per edge):
- Inputs are w0..w3 of row r.
- e = w0 + w2, f = w0 - w2, g = (w1>>>1) - w3, h = w1 + (w3>>>1). All arithmetic shifts, sign-extended to IN_W+1 bits.
- Row results replace row r as e+h, f+g, f-g, e-h, each IN_W+2 bits.
- After row 3: state -> OUT, row counter = 0.

OUT state:
- For output row r, apply the same butterfly down each column c of the row-transformed matrix. Row r selects e+h / f+g / f-g / e-h. Results are IN_W+4 bits.
- Rounding: x = (y + 32) >>> 6, then saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- XOUT, ROW and VALID are registered. The first row appears on the first edge in OUT.
- Timing from the 16th coefficient accepted at edge T, with the work matrix idle: transfer at T+1, rows at T+2..T+5, VALID=1 with row 0 after edge T+6.
- With OREADY held at 1, rows 1..3 follow at T+7..T+9.
- When VALID & ~OREADY, XOUT, ROW and VALID hold.
- On acceptance of row 3: VALID -> 0 and state -> IDLE. If load_full is also set, the transfer happens on the next edge.
- Zero-bubble hand-off is not required. Sustained throughput is one block per 16 input cycles when OREADY=1.

Test Plan:
- Block with WIN[0]=64, rest 0, OREADY=1 -> 4 rows, every residual +1, ROW 0,1,2,3, first VALID 6 cycles after last coefficient.
- WIN[0]=-64, rest 0 -> all residuals -1 (checks arithmetic rounding of -32>>>6).
- WIN[1]=64 (position (0,1)), rest 0 -> every row XOUT = {1,1,0,-1}, column 0 first.
- WIN[0]=32767, rest 0 -> all residuals saturate to 511; WIN[0]=-32768 -> all -512.
- Two back-to-back blocks with OREADY=0 for 20 cycles during the first block's output:
  - XOUT/ROW hold at row 0.
  - READY drops after the second block's 16th coefficient, and ENABLE is ignored while READY=0.
  - After OREADY=1, all 8 rows emerge in order with correct data.
- RESET=0 after 7 coefficients, then a full block with WIN[0]=64 -> only that block is output, all +1. RESET during OUT -> VALID=0 the next cycle.
